fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage; sits directly upstream of the control decoder.
//  - Owns the PC and issues one outstanding request at a time to instruction memory.
//  - Buffers the returned word and presents instr/pc plus decoded opcode/funct3/funct7
//    under a valid/ready handshake.
//  - Accepts branch/jump redirects from execute and squashes wrong-path fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address
//  NOP_INSTR 32'h0000_0013  value held in instr while instr_valid=0 (addi x0,x0,0)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst_n           in   1   asynchronous active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_addr       out  32  fetch address, word aligned ([1:0]=0)
//  imem_rsp_valid  in   1   response data valid (>=1 cycle after acceptance)
//  imem_rsp_data   in   32  instruction word
//  instr_valid     out  1   instr/pc/fields valid to decode
//  instr_ready     in   1   decode consumes instruction this cycle
//  instr           out  32  buffered instruction
//  pc              out  32  address of instr
//  pc_plus4        out  32  pc + 4 (mod 2^32), for JAL link
//  opcode          out  7   instr[6:0]
//  funct3          out  3   instr[14:12]
//  funct7          out  7   instr[31:25]
//  redirect_valid  in   1   taken branch/jump; overrides sequential PC
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=FETCH, fetch_pc=RESET_PC, kill=0, instr_valid=0
//   - instr=NOP_INSTR, pc=RESET_PC, imem_req_valid=0 while rst_n=0
//   - First request is driven in the first cycle after deassertion.
//  FETCH
//   - imem_req_valid=1, imem_addr=fetch_pc.
//   - Request is not committed until imem_req_ready, so imem_addr may change while ready=0.
//   - On ready: go to WAIT.
//  WAIT
//   - imem_req_valid=0.
//   - On rsp_valid with kill=0: latch instr<=data, pc<=fetch_pc, instr_valid<=1, go to HOLD.
//   - On rsp_valid with kill=1: drop the data, kill<=0, go to FETCH.
//  HOLD
//   - instr, pc and fields are stable while instr_valid=1 && instr_ready=0.
//   - On valid&&ready: instr_valid<=0, instr<=NOP_INSTR, fetch_pc<=pc+4, go to FETCH.
//  Redirect
//   - Any state: fetch_pc<=redirect_pc & ~3. Redirect has priority over sequential +4.
//   - HOLD: the buffered instr is dropped (instr_valid<=0 next cycle) whether or not
//     ready is high; go to FETCH.
//   - FETCH with ready=0: stay in FETCH; the new address is driven next cycle.
//   - FETCH with ready=1: the old address is accepted; kill<=1, go to WAIT.
//   - WAIT: kill<=1. The in-flight response is discarded, including one arriving in the
//     same cycle as the redirect.
//   - Repeated redirects before the response arrives: the last one wins; a single kill
//     covers them.
//  Other rules
//   - imem_rsp_valid outside WAIT is ignored (covers a stale response after reset).
//   - Latency: the request is issued the cycle after entry to FETCH. With ready=1 and a
//     1-cycle response, instr_valid rises 2 cycles after the request.
//   - Peak throughput is one instruction per 3 cycles.
//   - PC arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
//   - Field outputs are pure slices of instr, so they show NOP fields when idle.
//   - The output regs do not change combinationally from any input.
// TESTING
//  1 Reset release, ready=1, rsp 1 cycle later with 32'h00500093
//    -> req addr 0x0; instr_valid with pc=0, opcode=0010011, funct3=000.
//  2 Back-to-back consumption of 3 words -> pc sequence 0x0,0x4,0x8; pc_plus4=pc+4.
//  3 Hold: instr_ready=0 for 5 cycles -> instr/pc unchanged, no new imem request.
//  4 Redirect to 0x103 in WAIT; response 0xDEADBEEF arrives
//    -> word dropped; next req addr 0x100; instr_valid only for the 0x100 word.
//  5 valid&&ready&&redirect(0x40) in HOLD -> next req addr 0x40, not pc+4.
//  6 Wrap at fetch_pc=0xFFFFFFFC consumed -> next addr 0x0.
//    Also: rst_n pulse in WAIT -> outputs reset at once, late rsp ignored, refetch RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the control decoder.
//   Owns the PC, keeps at most one request outstanding to instruction memory,
//   buffers the returned word and presents it to decode under valid/ready.
//   Branch/jump redirects from execute override the sequential PC and squash
//   any wrong-path fetch that is still in flight.
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   imem_req_valid/ready, imem_addr request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data   response channel from instruction memory
//   instr_valid/ready               handshake with decode
//   instr, pc, pc_plus4             buffered instruction, its address, link value
//   opcode, funct3, funct7          field slices of instr
//   redirect_valid, redirect_pc     taken branch/jump target from execute
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target;

    assign target = redirect_pc & ~32'h3;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        kill_d        = kill_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        case (state_q)
            S_FETCH: begin
                // An accepted request carries the old address, so a redirect
                // in the same cycle must squash its response.
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    kill_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        instr_d       = imem_rsp_data;
                        pc_d          = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                // A redirect drops the buffered word whether or not decode takes it.
                if (redirect_valid || instr_ready) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    fetch_pc_d    = pc_q + 32'd4;
                    state_d       = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        if (redirect_valid) fetch_pc_d = target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            fetch_pc_q    <= RESET_PC;
            kill_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_q          <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            kill_q        <= kill_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
        end
    end

    // Held low during reset even though the state register already reads FETCH.
    assign imem_req_valid = (state_q == S_FETCH) && rst_n;
    assign imem_addr      = fetch_pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign opcode         = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign funct7         = instr_q[31:25];
endmodule
